multi_clk_div: RTL
==================

Name: multi_clk_div

Overview:
- Parametrised, runtime-programmable successor to the fixed multi-output clock divider.
- NUM_CH independent divider channels are driven from the 100 MHz board clock CLK.
- Each channel produces a square-wave enable clock (f = f_CLK / (2*(div+1))) and a one-cycle tick on every toggle.
- Divisors load at reset from a parameter and can be rewritten at run time. Channels can be enabled individually and phase-aligned together.
- Feeds audio sampling (20k/10k/5k), display refresh and UI debounce (5–100 Hz) logic.

Parameters:
- NUM_CH, 7, number of divider channels (1..16).
- CNT_W, 32, width of each counter and divisor.
- DIV_INIT, {7 x 32'd0}, packed NUM_CH*CNT_W reset divisors; channel i occupies bits [i*CNT_W +: CNT_W].

Ports:
- CLK  in  1  system clock, 100 MHz.
- RST  in  1  synchronous active-high reset.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  one-cycle strobe; phase-aligns all channels.
- wr  in  1  divisor write strobe.
- ch_sel  in  4  channel index for write and read-back.
- wr_data  in  CNT_W  new divisor value.
- rd_data  out  CNT_W  combinational div[ch_sel]; 0 if ch_sel >= NUM_CH.
- clk_out  out  NUM_CH  registered square-wave outputs.
- tick  out  NUM_CH  registered one-cycle pulse, asserted the same cycle clk_out[i] changes.

Behaviour:
- Single clock domain; all state updates on posedge CLK.
- Reset is synchronous and active-high.
- Per-channel state: div[i], cnt[i], clk_out[i], tick[i].
- RST=1: div[i]=DIV_INIT[i], cnt[i]=0, clk_out=0, tick=0.
- Priority per channel, highest first: RST > sync > write-hit > count.
- sync=1: every channel gets cnt=0, clk_out=0, tick=0. This applies regardless of en. A same-cycle write updates div but does not otherwise act.
- Write-hit (wr=1 and ch_sel==i, i<NUM_CH): div[i]=wr_data, cnt[i]=0, clk_out[i] unchanged, tick[i]=0. The new period starts the next cycle.
- wr with ch_sel >= NUM_CH is ignored; no state changes.
- Count (en[i]=1):
  - If cnt[i]==div[i]: cnt[i]=0, clk_out[i] toggles, tick[i]=1.
  - Otherwise: cnt[i]++, tick[i]=0.
- en[i]=0 (macro off): cnt[i] and clk_out[i] freeze at their current values; tick[i]=0.
- Toggle spacing is div+1 cycles. Full period is 2*(div+1) cycles.
- div=0: clk_out toggles every cycle (CLK/2); tick stays high continuously while enabled.
- div=2^CNT_W-1: cnt wraps to 0 only through the compare. There is no overflow path.
- Latency: the first toggle after RST release, sync or a write lands exactly div+1 enabled cycles later.
- Writing div lower than the current cnt is safe because the write clears cnt.
- rd_data reflects a write from the following cycle.
- Reset asserted mid-count aborts immediately; outputs are 0 on the next edge.

Optional Feature:
- Macro: CLKDIV_GLITCHFREE_GATE_EN.
- Defined: when en[i] falls while clk_out[i]=1, the channel keeps counting until its next toggle drives clk_out low, pulses tick once, then parks with cnt=0 and clk_out=0. If clk_out is already 0, it parks immediately with cnt=0. Re-asserting en resumes from cnt=0 with a low output. Output high-pulses are never truncated.
- Undefined: the freeze behaviour above; the output may stop high.

Test Plan:
- RST, DIV_INIT ch0=2499, en=all ones → clk_out[0] first rises 2500 cycles after RST release and period is 5000 cycles (20 kHz). tick[0] pulses every 2500 cycles.
- wr=1, ch_sel=1, wr_data=3 at cycle T → rd_data=3 at T+1. clk_out[1] toggles at T+4, T+8, …; level at the write is held until T+4.
- div=0 on ch2, en[2]=1 → clk_out[2] alternates every cycle; tick[2] stays high.
- Channels with divs 4 and 9, wait random cycles, pulse sync → both clk_out=0 and cnt=0. Ch A toggles at +5, ch B at +10; ch A and ch B edges coincide at +10.
- en[3] dropped while clk_out[3]=1 with div=9, 3 cycles after a rise:
  - Macro off: output holds 1 indefinitely.
  - Macro on: falls 7 cycles later, then stays 0.
- wr with ch_sel=9 (NUM_CH=7), plus RST asserted mid-period → no div change. The cycle after RST, all outputs are 0 and divisors equal DIV_INIT.

Source files
------------

// File: rtl/multi_clk_div.sv
// multi_clk_div
// Runtime-programmable bank of NUM_CH clock dividers sharing one clock.
// Each channel toggles its square-wave output every div+1 enabled cycles and
// pulses tick on the cycle the output changes. Divisors come from DIV_INIT at
// reset and can be rewritten through wr/ch_sel/wr_data; sync realigns every
// channel to a common phase.
// Optional build macro CLKDIV_GLITCHFREE_GATE_EN: a channel whose enable drops
// while its output is high keeps counting until the output falls, then parks
// low. Without the macro a disabled channel simply freezes in place.

module multi_clk_div #(
   parameter int NUM_CH = 7,
   parameter int CNT_W = 32,
   parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_CH-1:0] en,
   input  logic              sync,
   input  logic              wr,
   input  logic [3:0]        ch_sel,
   input  logic [CNT_W-1:0]  wr_data,
   output logic [CNT_W-1:0]  rd_data,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0]  div_q [NUM_CH];
   logic [CNT_W-1:0]  div_d [NUM_CH];
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] clkOut_q;
   logic [NUM_CH-1:0] clkOut_d;
   logic [NUM_CH-1:0] tick_q;
   logic [NUM_CH-1:0] tick_d;
   logic [NUM_CH-1:0] runCh;
   logic [NUM_CH-1:0] parkCh;

   // Decide which channels advance their counter this cycle and which are
   // forced back to a parked, zero-count state.
`ifdef CLKDIV_GLITCHFREE_GATE_EN
   always_comb begin
      runCh  = en | clkOut_q;
      parkCh = ~runCh;
   end
`else
   always_comb begin
      runCh  = en;
      parkCh = '0;
   end
`endif

   // Next-state for every channel: sync beats a write, a write beats counting,
   // and an idle channel either freezes or parks depending on the build.
   always_comb begin
      div_d    = div_q;
      cnt_d    = cnt_q;
      clkOut_d = clkOut_q;
      tick_d   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sync) begin
            cnt_d[i]    = '0;
            clkOut_d[i] = 1'b0;
            if (wr && (ch_sel == 4'(i))) begin
               div_d[i] = wr_data;
            end
         end else if (wr && (ch_sel == 4'(i))) begin
            div_d[i] = wr_data;
            cnt_d[i] = '0;
         end else if (runCh[i]) begin
            if (cnt_q[i] == div_q[i]) begin
               cnt_d[i]    = '0;
               clkOut_d[i] = ~clkOut_q[i];
               tick_d[i]   = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CntOne;
            end
         end else if (parkCh[i]) begin
            cnt_d[i] = '0;
         end
      end
   end

   // Read-back mux; an index beyond the last channel matches nothing and
   // returns zero.
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_sel == 4'(i)) begin
            rd_data = div_q[i];
         end
      end
   end

   // Channel state registers with synchronous reset back to the initial divisors.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NUM_CH; i++) begin
            div_q[i] <= DIV_INIT[i*CNT_W +: CNT_W];
            cnt_q[i] <= '0;
         end
         clkOut_q <= '0;
         tick_q   <= '0;
      end else begin
         div_q    <= div_d;
         cnt_q    <= cnt_d;
         clkOut_q <= clkOut_d;
         tick_q   <= tick_d;
      end
   end

   assign clk_out = clkOut_q;
   assign tick    = tick_q;

endmodule
